// File: rtl/gpio_pkg.sv
// Shared definitions for the APB GPIO slave: default widths, register word
// offsets (PADDR[4:2]) and the APB phase type.
package gpio_pkg;

  localparam int GPIO_PADDR_SIZE = 8;
  localparam int GPIO_PDATA_SIZE = 32;

  localparam logic [2:0] REG_DIR      = 3'd0;
  localparam logic [2:0] REG_OUT      = 3'd1;
  localparam logic [2:0] REG_IN       = 3'd2;
  localparam logic [2:0] REG_IRQ_EN   = 3'd3;
  localparam logic [2:0] REG_IRQ_TYPE = 3'd4;
  localparam logic [2:0] REG_IRQ_POL  = 3'd5;
  localparam logic [2:0] REG_IRQ_STAT = 3'd6;
  localparam logic [2:0] REG_RSVD     = 3'd7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_phase_t;

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer for the GPIO pins plus a one-cycle-delayed copy of
// the synchronized value used for edge detection.
module gpio_sync #(
  parameter int WIDTH = 32
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] prev
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

endmodule

// File: rtl/apb_gpio_slave.sv
// Zero-wait APB GPIO completer: direction/output registers, synchronized
// inputs and a level/edge interrupt block with W1C status.
//
// phase_q holds the bus phase of the previous cycle; phase_d is the phase of
// the current cycle derived from it and PSEL/PENABLE.
//   state  | meaning
//   IDLE   | no transfer in progress
//   SETUP  | first cycle of a transfer, read data / error captured at its edge
//   ACCESS | second cycle, PREADY high, writes commit at its edge
module apb_gpio_slave
  import gpio_pkg::*;
#(
  parameter int PADDR_SIZE = GPIO_PADDR_SIZE,
  parameter int PDATA_SIZE = GPIO_PDATA_SIZE
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [PDATA_SIZE-1:0]   gpio_i,
  output logic [PDATA_SIZE-1:0]   gpio_o,
  output logic [PDATA_SIZE-1:0]   gpio_oe,
  output logic                    irq_o
);

  apb_phase_t phase_q, phase_d;

  logic [2:0]            addr_idx;
  logic                  addr_err;
  logic                  wr_commit;
  logic                  pslverr_q;
  logic                  irq_q;
  logic                  unused_paddr;
  logic [PDATA_SIZE-1:0] dir_q, out_q, en_q, type_q, pol_q, status_q;
  logic [PDATA_SIZE-1:0] sync_q, prev_q;
  logic [PDATA_SIZE-1:0] wmask, rdata, evt, w1c, prdata_q;

  gpio_sync #(.WIDTH(PDATA_SIZE)) u_sync (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .d      (gpio_i),
    .sync   (sync_q),
    .prev   (prev_q)
  );

  assign addr_idx     = PADDR[4:2];
  assign unused_paddr = ^PADDR;
  assign addr_err     = (addr_idx == REG_RSVD) || (PWRITE && (addr_idx == REG_IN));

  always_comb begin
    phase_d = IDLE;
    unique case (phase_q)
      IDLE:    if (PSEL && !PENABLE) phase_d = SETUP;
      SETUP: begin
        if (PSEL && PENABLE) phase_d = ACCESS;
        else if (PSEL)       phase_d = SETUP;
      end
      ACCESS:  if (PSEL && !PENABLE) phase_d = SETUP;
      default: phase_d = IDLE;
    endcase
  end

  assign wr_commit = (phase_d == ACCESS) && PWRITE && !addr_err;

  always_comb begin
    wmask = '0;
    for (int i = 0; i < PDATA_SIZE/8; i++) wmask[8*i +: 8] = {8{PSTRB[i]}};
  end

  always_comb begin
    rdata = '0;
    case (addr_idx)
      REG_DIR:      rdata = dir_q;
      REG_OUT:      rdata = out_q;
      REG_IN:       rdata = sync_q;
      REG_IRQ_EN:   rdata = en_q;
      REG_IRQ_TYPE: rdata = type_q;
      REG_IRQ_POL:  rdata = pol_q;
      REG_IRQ_STAT: rdata = status_q;
      default:      rdata = '0;
    endcase
  end

  // Per bit: edge mode uses sync/prev against polarity, level mode compares sync to polarity.
  assign evt = (type_q  & ((pol_q & sync_q & ~prev_q) | (~pol_q & ~sync_q & prev_q)))
             | (~type_q & ~(sync_q ^ pol_q));

  assign w1c = (wr_commit && (addr_idx == REG_IRQ_STAT)) ? (PWDATA & wmask) : '0;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      phase_q   <= IDLE;
      prdata_q  <= '0;
      pslverr_q <= 1'b0;
      dir_q     <= '0;
      out_q     <= '0;
      en_q      <= '0;
      type_q    <= '0;
      pol_q     <= '0;
      status_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (phase_d == SETUP) begin
        prdata_q  <= (!PWRITE && !addr_err) ? rdata : '0;
        pslverr_q <= addr_err;
      end else begin
        prdata_q  <= '0;
        pslverr_q <= 1'b0;
      end
      if (wr_commit) begin
        case (addr_idx)
          REG_DIR:      dir_q  <= (dir_q  & ~wmask) | (PWDATA & wmask);
          REG_OUT:      out_q  <= (out_q  & ~wmask) | (PWDATA & wmask);
          REG_IRQ_EN:   en_q   <= (en_q   & ~wmask) | (PWDATA & wmask);
          REG_IRQ_TYPE: type_q <= (type_q & ~wmask) | (PWDATA & wmask);
          REG_IRQ_POL:  pol_q  <= (pol_q  & ~wmask) | (PWDATA & wmask);
          default: ;
        endcase
      end
      // Events are OR-ed in after the clear so a same-cycle set wins.
      status_q <= (status_q & ~w1c) | evt;
      irq_q    <= |(status_q & en_q);
    end
  end

  assign PREADY  = (phase_d == ACCESS);
  assign PSLVERR = pslverr_q & PREADY;
  assign PRDATA  = prdata_q;
  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;
  assign irq_o   = irq_q;

endmodule
